// File: rtl/regfile_pkg.sv
// Shared sizing and requester indices for the register-file writeback arbiter.
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 2**AW;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;
endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding register. When load and clear occur together, load wins,
// so a granted entry can be replaced in the same cycle.
module wb_slot #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          clear_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o
);
  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (clear_i) valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester arbiter for the register file's single write port, with x0 discard and pending-write map.
// Define WB_RR_EN to get round-robin arbitration; without it, req0 has fixed priority.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int AW   = regfile_pkg::AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [AW-1:0]     req0_addr,
  input  logic [XLEN-1:0]   req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [AW-1:0]     req1_addr,
  input  logic [XLEN-1:0]   req1_data,
  output logic              WE3,
  output logic [AW-1:0]     A3,
  output logic [XLEN-1:0]   WD1,
  output logic [2**AW-1:0]  pend,
  output logic              busy
);
  logic [1:0]      req_valid, req_ready;
  logic [1:0]      slot_vld, slot_load, slot_clr, elig, gnt;
  logic [AW-1:0]   req_addr  [2];
  logic [XLEN-1:0] req_data  [2];
  logic [AW-1:0]   slot_addr [2];
  logic [XLEN-1:0] slot_data [2];

  assign req_valid   = {req1_valid, req0_valid};
  assign req_addr[0] = req0_addr;
  assign req_addr[1] = req1_addr;
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;
  assign req0_ready  = req_ready[0];
  assign req1_ready  = req_ready[1];

  // A slot is freed when it is granted or when it holds an x0 write.
  for (genvar i = 0; i < 2; i++) begin : g_slot
    assign elig[i]      = slot_vld[i] && (slot_addr[i] != '0);
    assign slot_clr[i]  = slot_vld[i] && (!elig[i] || gnt[i]);
    assign req_ready[i] = rst_n && (!slot_vld[i] || slot_clr[i]);
    assign slot_load[i] = req_valid[i] && req_ready[i];

    wb_slot #(.AW(AW), .DW(XLEN)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (slot_load[i]),
      .clear_i (slot_clr[i]),
      .addr_i  (req_addr[i]),
      .data_i  (req_data[i]),
      .valid_o (slot_vld[i]),
      .addr_o  (slot_addr[i]),
      .data_o  (slot_data[i])
    );
  end

`ifdef WB_RR_EN
  logic last_gnt_q, last_gnt_d;

  always_comb begin
    gnt = elig;
    if (&elig) gnt = (last_gnt_q == REQ_LSU) ? 2'b01 : 2'b10;
  end

  assign last_gnt_d = (&elig) ? gnt[REQ_LSU] : last_gnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_gnt_q <= REQ_LSU;
    else        last_gnt_q <= last_gnt_d;
  end
`else
  always_comb begin
    gnt = elig;
    if (&elig) gnt = 2'b01;
  end
`endif

  always_comb begin
    WE3 = |gnt;
    A3  = '0;
    WD1 = '0;
    if (gnt[REQ_ALU]) begin
      A3  = slot_addr[REQ_ALU];
      WD1 = slot_data[REQ_ALU];
    end else if (gnt[REQ_LSU]) begin
      A3  = slot_addr[REQ_LSU];
      WD1 = slot_data[REQ_LSU];
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < 2; i++)
      if (elig[i]) pend[slot_addr[i]] = 1'b1;
  end

  assign busy = |slot_vld;
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the dual-read, single-write register file: two writeback requesters (req0 = ALU writeback, req1 = load/multi-cycle unit) share the register file's only write port (WE3/A3/WD1). Each requester has a valid/ready handshake into a one-entry holding slot. The block arbitrates between pending slots and drives the write port. It also discards writes to register x0 and exports a pending-write scoreboard for hazard logic.

## Interface
Parameters:
- XLEN, 32, data width of a register write
- AW, 5, register address width; the register file has 2**AW entries

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req0_valid  in  1  requester 0 offers a write
- req0_ready  out  1  requester 0 slot can accept this cycle
- req0_addr  in  AW  destination register, requester 0
- req0_data  in  XLEN  write data, requester 0
- req1_valid / req1_ready / req1_addr / req1_data  same meaning, requester 1
- WE3  out  1  register file write enable
- A3  out  AW  register file write address
- WD1  out  XLEN  register file write data
- pend  out  2**AW  bit i set while any slot holds a write to register i
- busy  out  1  any slot occupied

## Operation
- Each requester owns one slot: valid bit, addr, and data.
- A transfer occurs on a rising edge where reqN_valid and reqN_ready are both 1. The slot loads addr and data and sets valid.
- reqN_ready = !slotN.valid || slotN is granted or discarded this cycle. This gives one write per cycle per requester when uncontested.
- Discard: a slot holding addr 0 is freed on the next edge. It never asserts WE3 and does not take part in arbitration.
- Eligible slots are valid with nonzero addr.
  - One eligible: that slot is granted.
  - Two eligible: round-robin on pointer last_gnt. The slot not granted last time wins.
- The granted slot drives WE3=1, A3=addr, WD1=data combinationally. It is cleared on that edge, unless it is reloaded by a simultaneous new transfer.
- last_gnt updates only on a contested grant (both slots eligible).
- With no grant: WE3=0, A3=0, WD1=0.
- pend is the OR of one-hot(addr) over valid slots with nonzero addr. pend[0] is always 0.
- No ordering guarantee between requesters. Same-address writes from both requesters complete in grant order.

## Timing
- Reset values:
  - slots empty
  - last_gnt = 1, so req0 wins the first contest
  - WE3=0, A3=0, WD1=0, pend=0, busy=0
  - req0_ready=1 and req1_ready=1 while rst_n is high; both are forced to 0 while rst_n is low
- Latency: a transfer at edge k with no contention gives WE3=1 in cycle k..k+1, and the register file writes at edge k+1.
- Contended: the loser writes one cycle after the winner. Worst-case latency is 2 edges.
- Reset mid-operation: pending slots are dropped with no write. Write outputs go to 0 immediately (asynchronous).
- A simultaneous grant and new transfer into the same slot is legal. The old entry is written and the new entry is held.

## Configuration
- WB_RR_EN defined: round-robin arbitration as above.
- WB_RR_EN undefined: fixed priority, req0 always wins a contest, and last_gnt is not implemented. A continuously valid req0 can starve req1; this is acceptable for the single-issue core.

## Structure
- Package regfile_pkg: XLEN, AW, NREG = 2**AW, requester index constants REQ_ALU=0 and REQ_LSU=1.
- Sub-module wb_slot: one-entry holding register with load/clear and valid/addr/data outputs. It is instantiated twice.
- The top level holds the arbitration, the last_gnt flop, the output mux, and the pend decode.

## Test plan
- Reset, then req0 writes addr 3, data 0x0000_00AC -> WE3=1, A3=3, WD1=0xAC for exactly one cycle. pend[3]=1 during that cycle, then 0.
- Both requesters valid in the same cycle (addr 1 / 0xF0, addr 2 / 0x0F) -> req0 written first, req1 the next cycle. Repeat -> req1 first (WB_RR_EN only).
- req1 writes addr 0, data 0xFFFF_FFFF -> WE3 stays 0, slot freed next edge, req1_ready back to 1, pend stays 0.
- req0 streams 4 back-to-back writes (addrs 0..3, data 0xAC/0xF0/0x0F/0xC3) with req1 idle -> req0_ready held 1. WE3 asserted for addrs 1..3 on consecutive cycles.
- rst_n pulled low while both slots are pending -> WE3, A3, WD1, and pend go to 0 asynchronously. No write occurs after release.
- Without WB_RR_EN: req0 and req1 both continuously valid -> every grant goes to req0 and req1_ready stays 0.
